nmi2apb_bridge: RTL and testbench

- Converts the native memory interface (NMI) request stream from the SoC bus decoder's APB branch into AMBA APB3/APB4 single transfers.
- Upstream: the decoder's APB-branch NMI master, carrying FLASH and custom-IP address windows. Downstream: the APB interconnect and peripherals.
- Exactly one outstanding transfer at a time.
- Adds a programmable timeout so that a hung peripheral cannot stall the core.

---
 rtl/nmi_apb_pkg.sv | 13 +
 rtl/nmi2apb_bridge.sv | 117 +++++++++++
 tb/tb_nmi2apb_bridge.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nmi_apb_pkg.sv
// Shared types and constants for the NMI-to-APB bridge.
package nmi_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    localparam logic [31:0] APB_ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi2apb_bridge.sv
// NMI request to APB single-transfer bridge, one transfer outstanding,
// with an optional ACCESS-phase timeout against hung peripherals.
module nmi2apb_bridge
    import nmi_apb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = APB_ERR_RDATA_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              nmi_valid_i,
    input  logic [31:0]       nmi_addr_i,
    input  logic [31:0]       nmi_wdata_i,
    input  logic [3:0]        nmi_wstrb_i,
    output logic [31:0]       nmi_rdata_o,
    output logic              nmi_ready_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [31:0]       pwdata_o,
    output logic [3:0]        pstrb_o,
    input  logic [31:0]       prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              err_o
);

    // Keep at least one counter bit so TIMEOUT=0 still elaborates.
    localparam int unsigned     CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (nmi_valid_i) begin
                    paddr_d  = nmi_addr_i[ADDR_W-1:0];
                    pwdata_d = nmi_wdata_i;
                    pstrb_d  = nmi_wstrb_i;
                    pwrite_d = |nmi_wstrb_i;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (pready_i) begin
                    rdata_d = pwrite_q ? 32'h0 : (pslverr_i ? ERR_RDATA : prdata_i);
                    err_d   = pslverr_i;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    rdata_d = pwrite_q ? 32'h0 : ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Control outputs decode straight from state so reset drops them at once.
    assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o   = (state_q == ACCESS);
    assign nmi_ready_o = (state_q == RESP);
    assign err_o       = (state_q == RESP) && err_q;
    assign nmi_rdata_o = rdata_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign pwrite_o    = pwrite_q;

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Self-checking bench for nmi2apb_bridge against a transaction-level model.
module tb_nmi2apb_bridge;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nmi_valid = 1'b0;
    logic [31:0] nmi_addr = '0;
    logic [31:0] nmi_wdata = '0;
    logic [3:0]  nmi_wstrb = '0;
    logic [31:0] nmi_rdata;
    logic        nmi_ready;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nmi2apb_bridge #(
        .ADDR_W   (32),
        .TIMEOUT  (TO),
        .ERR_RDATA(ERR)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .nmi_valid_i(nmi_valid),
        .nmi_addr_i (nmi_addr),
        .nmi_wdata_i(nmi_wdata),
        .nmi_wstrb_i(nmi_wstrb),
        .nmi_rdata_o(nmi_rdata),
        .nmi_ready_o(nmi_ready),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .err_o      (err)
    );

    // One transfer: the model says how many ACCESS cycles it takes, when
    // nmi_ready must pulse (in edges from the call) and what it returns.
    // chained=1 means the call starts in the previous transfer's RESP cycle.
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int waits, input bit slverr,
                           input logic [31:0] prd, input bit chained, input bit drop_valid);
        bit          is_wr, to;
        int          exp_acc, exp_edge, cap_edge, acc_n, seen;
        logic [31:0] exp_rd;
        logic [68:0] exp_bus;
        is_wr    = (wstrb != 4'b0);
        to       = (waits >= TO);
        exp_acc  = to ? TO : waits + 1;
        cap_edge = chained ? 2 : 1;
        exp_edge = 2 + exp_acc + (chained ? 1 : 0);
        exp_rd   = is_wr ? 32'h0 : ((to || slverr) ? ERR : prd);
        exp_bus  = {is_wr, addr, wdata, wstrb};
        if (!chained) begin
            nmi_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            if (nmi_ready !== 1'b0 || psel !== 1'b0) begin
                bad++;
                $display("FAIL idle_gap: ready=%b psel=%b, required 0 0", nmi_ready, psel);
            end
        end
        nmi_valid = 1'b1;
        nmi_addr  = addr;
        nmi_wdata = wdata;
        nmi_wstrb = wstrb;
        acc_n = 0;
        seen  = 0;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(posedge clk); #1;
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = $urandom;
            if (c == cap_edge) begin
                total++;
                if ({psel, penable} !== 2'b10 || {pwrite, paddr, pwdata, pstrb} !== exp_bus) begin
                    bad++;
                    $display("FAIL setup: sel/en=%b%b bus=%h, required 10 bus=%h",
                             psel, penable, {pwrite, paddr, pwdata, pstrb}, exp_bus);
                end
                // Inputs after capture must not reach the bus.
                nmi_addr  = $urandom;
                nmi_wdata = $urandom;
                nmi_wstrb = 4'($urandom);
                if (drop_valid) nmi_valid = 1'b0;
            end
            if (psel && penable) begin
                acc_n++;
                total++;
                if ({pwrite, paddr, pwdata, pstrb} !== exp_bus) begin
                    bad++;
                    $display("FAIL access_bus: cycle %0d bus=%h, required %h",
                             acc_n, {pwrite, paddr, pwdata, pstrb}, exp_bus);
                end
                if (acc_n - 1 == waits) begin
                    pready  = 1'b1;
                    pslverr = slverr;
                    prdata  = prd;
                end
            end
            total++;
            if (!nmi_ready && err) begin
                bad++;
                $display("FAIL err_stray: err=1 without nmi_ready at edge %0d", c);
            end
            if (nmi_ready) begin
                seen = c;
                total++;
                if (c != exp_edge) begin
                    bad++;
                    $display("FAIL latency: ready at edge %0d, required %0d", c, exp_edge);
                end
                total++;
                if (nmi_rdata !== exp_rd || err !== (to || slverr)) begin
                    bad++;
                    $display("FAIL resp: rdata=%h err=%b, required rdata=%h err=%b",
                             nmi_rdata, err, exp_rd, to || slverr);
                end
                total++;
                if (psel !== 1'b0 || penable !== 1'b0) begin
                    bad++;
                    $display("FAIL resp_bus: sel/en=%b%b, required 00", psel, penable);
                end
                nmi_valid = 1'b0;
            end
        end
        total++;
        if (seen == 0 || acc_n != exp_acc) begin
            bad++;
            $display("FAIL access_count: ready_edge=%0d access=%0d, required %0d access=%0d",
                     seen, acc_n, exp_edge, exp_acc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({nmi_ready, psel, penable, pwrite, err, paddr, pwdata, pstrb, nmi_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_values: outputs not all zero (ready=%b psel=%b paddr=%h)",
                     nmi_ready, psel, paddr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_xfer(32'h1000_0004, 32'h0, 4'b0000, 0, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0);
        do_xfer(32'h2000_0010, 32'hCAFE_F00D, 4'b0101, 3, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
        do_xfer(32'h1000_0008, 32'h0, 4'b0000, 0, 1'b1, 32'h5555_6666, 1'b0, 1'b0);
        do_xfer(32'h2000_0020, 32'h1234_5678, 4'b1111, 1, 1'b1, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_xfer(32'h3000_0000, 32'h0, 4'b0000, 100, 1'b0, 32'h0, 1'b0, 1'b0);
        do_xfer(32'h3000_0004, 32'h7777_8888, 4'b0011, 100, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pready = 1'b1;
            @(posedge clk); #1;
            total++;
            if (nmi_ready !== 1'b0 || psel !== 1'b0) begin
                bad++;
                $display("FAIL late_pready: ready=%b psel=%b, required 0 0", nmi_ready, psel);
            end
        end
        pready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc_n;
        acc_n = 0;
        nmi_valid = 1'b1;
        nmi_addr  = 32'h4000_0000;
        nmi_wstrb = 4'b0000;
        for (int c = 0; c < 20 && acc_n < 2; c++) begin
            @(posedge clk); #1;
            if (psel && penable) acc_n++;
        end
        total++;
        if (acc_n != 2) begin
            bad++;
            $display("FAIL reset_mid_reach: access=%0d, required 2", acc_n);
        end
        #2;
        rst_n = 1'b0;
        nmi_valid = 1'b0;
        #1;
        total++;
        if ({psel, penable, nmi_ready} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_drop: sel/en/ready=%b%b%b, required 000",
                     psel, penable, nmi_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            pready = 1'b1;
            total++;
            if (nmi_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_ready: ready=%b, required 0", nmi_ready);
            end
        end
        pready = 1'b0;
        rst_n  = 1'b1;
        do_xfer(32'h4000_0008, 32'h0, 4'b0000, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h5000_0000, 32'h0, 4'b0000, 0, 1'b0, 32'hAAAA_0001, 1'b0, 1'b0);
        do_xfer(32'h5000_0040, 32'h0, 4'b0000, 0, 1'b0, 32'hBBBB_0002, 1'b1, 1'b0);
        do_xfer(32'h5000_0080, 32'h9999_0000, 4'b1000, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] ws;
        for (int i = 0; i < 40; i++) begin
            ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            do_xfer($urandom, $urandom, ws, $urandom_range(0, 9), 1'($urandom), $urandom,
                    1'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
